alu_serial_loader: RTL and testbench
====================================

# alu_serial_loader

Serial command transmitter that drives the TMR ALU's bit-serial input port. It accepts a parallel command (opcode plus two operands) through a valid/ready handshake. It then shifts the command out one bit per clock on a single data line and pulses a one-cycle frame strobe, which connects to the ALU's `Ready` input. It sits between the Wishbone/LA-side control logic and the ALU inside the user project wrapper.

## Interface
Parameters:
- `OP_W`, default 4: opcode width in bits.
- `DATA_W`, default 16: width of each operand in bits.
- `GAP_CYCLES`, default 2: mandatory idle cycles after each strobe; 0 is legal.

Ports:
- `CLK` input 1: the single clock; all logic is on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `CMD_VALID` input 1: a command is presented.
- `CMD_READY` output 1: the loader can accept a command.
- `CMD_OP` input OP_W: opcode.
- `CMD_A` input DATA_W: operand A.
- `CMD_B` input DATA_W: operand B.
- `DATA_OUT` output 1: serial bit stream, connects to the ALU `DATA_IN`.
- `READY_OUT` output 1: one-cycle end-of-frame strobe, connects to the ALU `Ready`.
- `BUSY` output 1: high whenever the loader is not in IDLE.
- `FRAME_CNT` output 8: count of completed frames; wraps from 255 to 0.

## Operation
- Frame format: `CMD_OP`, then `CMD_A`, then `CMD_B`, each field MSB first.
- FRAME_LEN = OP_W + 2·DATA_W, which is 36 at the defaults. It is +1 when parity is enabled.
- State machine:
  - IDLE → SHIFT when CMD_VALID && CMD_READY. The whole frame is captured into a shift register on that edge.
  - SHIFT → STROBE after FRAME_LEN bits have been driven.
  - STROBE → GAP, or → IDLE if GAP_CYCLES = 0.
  - GAP → IDLE after GAP_CYCLES cycles.
- All outputs are registered. `CMD_READY` = 1 only in IDLE.
- In SHIFT, `DATA_OUT` = the current shift-register MSB. In every other state `DATA_OUT` = 0.
- `READY_OUT` = 1 only in STROBE.
- `FRAME_CNT` increments on entry to STROBE.
- While not in IDLE, `CMD_VALID` and the command buses are ignored. Commands are never queued.
- A bit counter of width ⌈log2(FRAME_LEN+1)⌉ counts down from FRAME_LEN. The SHIFT→STROBE transition happens on the edge where the counter reaches 1.
- Reset values: `CMD_READY` = 0 while RST is low, then 1 on the first edge after release. `DATA_OUT` = 0, `READY_OUT` = 0, `BUSY` = 0, `FRAME_CNT` = 0. The state is IDLE and the shift register is cleared.
- Reset mid-frame: the outputs clear asynchronously and the partial frame is discarded. There is no strobe and `FRAME_CNT` is not incremented.

## Timing
- Let edge 0 be the acceptance edge.
- Bit k of the frame (k = 1..FRAME_LEN) is valid on `DATA_OUT` during cycle k, i.e. after edge k−1.
- `READY_OUT` is high during cycle FRAME_LEN+1.
- `CMD_READY` returns high in cycle FRAME_LEN+2+GAP_CYCLES.
- Throughput: one command every FRAME_LEN+2+GAP_CYCLES cycles.
- Back-to-back: if `CMD_VALID` is held high, the next command is accepted on the first IDLE edge. There are no extra bubbles.

## Configuration
- Macro `ALU_LOADER_PARITY_EN`:
  - When defined, one even-parity bit (XOR of all OP, A and B bits) is appended after the B LSB. FRAME_LEN grows by 1 and every later event shifts one cycle later.
  - When undefined, no parity bit is sent and the frame is exactly OP_W + 2·DATA_W bits.

## Test plan
All scenarios use default parameters.
- **Basic frame.** Reset, then one command: OP = 4'h3, A = 16'h00FF, B = 16'h0001.
  - `DATA_OUT` over cycles 1..36 = 0011, then 0000000011111111, then 0000000000000001.
  - `READY_OUT` = 1 in cycle 37 only.
  - `CMD_READY` = 1 again in cycle 40.
  - `FRAME_CNT` = 1.
- **Parity build.** Same command with `ALU_LOADER_PARITY_EN` defined.
  - The 11 set bits give parity bit 1 in cycle 37.
  - Strobe in cycle 38; `CMD_READY` in cycle 41.
- **Back-to-back with busy-time changes.** Hold `CMD_VALID` = 1 with OP = 4'hF, A = 16'hAAAA, B = 16'h5555, and change the buses while BUSY.
  - The second frame carries the values present at edge 40.
  - The first frame is unaffected by the bus changes.
  - Exactly 2 idle-gap cycles of `DATA_OUT` = 0 and `READY_OUT` = 0 lie between the strobes.
- **Reset mid-frame.** Assert RST low in cycle 20.
  - All outputs go to 0 immediately.
  - There is no strobe and `FRAME_CNT` = 0.
  - After release, a new command produces a clean 36-bit frame.
- **Counter wrap.** Send 256 frames.
  - `FRAME_CNT` wraps from 255 to 0.
  - `READY_OUT` is counted exactly 256 times.
- **GAP_CYCLES = 0.** Instantiate with GAP_CYCLES = 0.
  - `CMD_READY` returns in cycle 38.
  - With `CMD_VALID` held, the second frame's first bit appears in cycle 39.

Source files
------------

// File: rtl/alu_serial_loader.sv
// Bit-serial command transmitter for the TMR ALU: OP, A, B shifted out MSB first, then a frame strobe.
// Optional even-parity trailer bit enabled by defining ALU_LOADER_PARITY_EN.
`timescale 1ns/1ps
module alu_serial_loader #(
  parameter int unsigned OP_W       = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [OP_W-1:0]   CMD_OP,
  input  logic [DATA_W-1:0] CMD_A,
  input  logic [DATA_W-1:0] CMD_B,
  output logic              DATA_OUT,
  output logic              READY_OUT,
  output logic              BUSY,
  output logic [7:0]        FRAME_CNT
);

  localparam int unsigned PAY_W = OP_W + 2 * DATA_W;
`ifdef ALU_LOADER_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned FRAME_LEN = PAY_W + PAR_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_STROBE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [PAY_W-1:0]     payload_c;
  logic [FRAME_LEN-1:0] frame_c;

  // Frame image captured on the acceptance edge
  assign payload_c = {CMD_OP, CMD_A, CMD_B};
`ifdef ALU_LOADER_PARITY_EN
  assign frame_c = {payload_c, ^payload_c};
`else
  assign frame_c = payload_c;
`endif

  // DATA_OUT always mirrors the MSB the shift register holds during SHIFT
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      CMD_READY <= 1'b0;
      DATA_OUT  <= 1'b0;
      READY_OUT <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            state     <= S_SHIFT;
            shreg     <= frame_c;
            bit_cnt   <= CNT_W'(FRAME_LEN);
            DATA_OUT  <= frame_c[FRAME_LEN-1];
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == CNT_W'(1)) begin
            state     <= S_STROBE;
            DATA_OUT  <= 1'b0;
            READY_OUT <= 1'b1;
            FRAME_CNT <= 8'(FRAME_CNT + 8'd1);
          end else begin
            shreg    <= {shreg[FRAME_LEN-2:0], 1'b0};
            DATA_OUT <= shreg[FRAME_LEN-2];
            bit_cnt  <= CNT_W'(bit_cnt - CNT_W'(1));
          end
        end
        S_STROBE: begin
          READY_OUT <= 1'b0;
          if (GAP_CYCLES == 0) begin
            state     <= S_IDLE;
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
          end else begin
            state   <= S_GAP;
            gap_cnt <= GAP_W'(GAP_LOAD);
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state     <= S_IDLE;
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
          end else begin
            gap_cnt <= GAP_W'(gap_cnt - GAP_W'(1));
          end
        end
        default: begin
          state     <= S_IDLE;
          DATA_OUT  <= 1'b0;
          READY_OUT <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_loader.sv
// Directed bench for alu_serial_loader: default instance (gap 2) and a gap-0 instance share stimulus.
`timescale 1ns/1ps
module tb_alu_serial_loader;

`ifdef ALU_LOADER_PARITY_EN
  localparam int unsigned FL = 37;
  localparam logic [FL-1:0] F_BASIC = {36'h3_00FF_0001, 1'b1};
  localparam logic [FL-1:0] F_B2B1  = {36'hF_AAAA_5555, 1'b0};
  localparam logic [FL-1:0] F_B2B2  = {36'h1_1234_BEEF, 1'b1};
`else
  localparam int unsigned FL = 36;
  localparam logic [FL-1:0] F_BASIC = 36'h3_00FF_0001;
  localparam logic [FL-1:0] F_B2B1  = 36'hF_AAAA_5555;
  localparam logic [FL-1:0] F_B2B2  = 36'h1_1234_BEEF;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;

  logic        crdy0, dout0, rdy0, busy0;
  logic [7:0]  fcnt0;
  logic        crdy1, dout1, rdy1, busy1;
  logic [7:0]  fcnt1;

  int sel;
  logic       crdy, dout, rdy, busy;
  logic [7:0] fcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_serial_loader #(.OP_W(4), .DATA_W(16), .GAP_CYCLES(2)) dut (
    .CLK(clk), .RST(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(crdy0),
    .CMD_OP(cmd_op), .CMD_A(cmd_a), .CMD_B(cmd_b),
    .DATA_OUT(dout0), .READY_OUT(rdy0), .BUSY(busy0), .FRAME_CNT(fcnt0)
  );

  alu_serial_loader #(.OP_W(4), .DATA_W(16), .GAP_CYCLES(0)) dut_gap0 (
    .CLK(clk), .RST(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(crdy1),
    .CMD_OP(cmd_op), .CMD_A(cmd_a), .CMD_B(cmd_b),
    .DATA_OUT(dout1), .READY_OUT(rdy1), .BUSY(busy1), .FRAME_CNT(fcnt1)
  );

  assign crdy = (sel == 1) ? crdy1 : crdy0;
  assign dout = (sel == 1) ? dout1 : dout0;
  assign rdy  = (sel == 1) ? rdy1  : rdy0;
  assign busy = (sel == 1) ? busy1 : busy0;
  assign fcnt = (sel == 1) ? fcnt1 : fcnt0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    cmd_op = op;
    cmd_a  = a;
    cmd_b  = b;
  endtask

  // Entered in cycle 1 of a frame; leaves in the cycle where CMD_READY should be back.
  task automatic check_frame(input logic [FL-1:0] exp, input logic [7:0] exp_cnt,
                             input int gap, input string name);
    logic [FL-1:0] got;
    int rdy_hi;
    rdy_hi = 0;
    checks++;
    if (busy !== 1'b1 || crdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_cycle1 busy=%b cmd_ready=%b required busy=1 cmd_ready=0", name, busy, crdy);
    end
    for (int k = 0; k < int'(FL); k++) begin
      got[FL-1-k] = dout;
      if (rdy === 1'b1) rdy_hi++;
      if (k != int'(FL) - 1) step();
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_bits got=%h required=%h", name, got, exp);
    end
    checks++;
    if (rdy_hi != 0) begin
      errors++;
      $display("FAIL %s_early_strobe ready_out high %0d cycles during shift, required 0", name, rdy_hi);
    end
    step();
    checks++;
    if (rdy !== 1'b1 || dout !== 1'b0 || fcnt !== exp_cnt || crdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_strobe ready_out=%b data_out=%b frame_cnt=%0d cmd_ready=%b required 1 0 %0d 0",
               name, rdy, dout, fcnt, crdy, exp_cnt);
    end
    for (int g = 0; g < gap; g++) begin
      step();
      checks++;
      if (rdy !== 1'b0 || dout !== 1'b0 || crdy !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_gap%0d ready_out=%b data_out=%b cmd_ready=%b busy=%b required 0 0 0 1",
                 name, g, rdy, dout, crdy, busy);
      end
    end
    step();
    checks++;
    if (crdy !== 1'b1 || rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle cmd_ready=%b ready_out=%b busy=%b required 1 0 0", name, crdy, rdy, busy);
    end
  endtask

  task automatic test_reset;
    sel = 0;
    cmd_valid = 1'b0;
    set_cmd(4'h0, 16'h0, 16'h0);
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (crdy !== 1'b0 || dout !== 1'b0 || rdy !== 1'b0 || busy !== 1'b0 || fcnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_held cmd_ready=%b data_out=%b ready_out=%b busy=%b frame_cnt=%0d required all 0",
               crdy, dout, rdy, busy, fcnt);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (crdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release cmd_ready=%b busy=%b required 1 0", crdy, busy);
    end
  endtask

  task automatic test_basic;
    sel = 0;
    do_reset();
    set_cmd(4'h3, 16'h00FF, 16'h0001);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check_frame(F_BASIC, 8'd1, 2, "basic");
    checks++;
    if (fcnt !== 8'd1) begin
      errors++;
      $display("FAIL basic_frame_cnt got=%0d required=1", fcnt);
    end
  endtask

  task automatic test_back_to_back;
    sel = 0;
    do_reset();
    set_cmd(4'hF, 16'hAAAA, 16'h5555);
    cmd_valid = 1'b1;
    step();
    set_cmd(4'h1, 16'h1234, 16'hBEEF);
    check_frame(F_B2B1, 8'd1, 2, "b2b_first");
    step();
    check_frame(F_B2B2, 8'd2, 2, "b2b_second");
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int strobes;
    sel = 0;
    do_reset();
    set_cmd(4'h3, 16'h00FF, 16'h0001);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k < 20; k++) step();
    checks++;
    if (dout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before data_out=%b busy=%b required 1 1", dout, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (crdy !== 1'b0 || dout !== 1'b0 || rdy !== 1'b0 || busy !== 1'b0 || fcnt !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async cmd_ready=%b data_out=%b ready_out=%b busy=%b frame_cnt=%0d required all 0",
               crdy, dout, rdy, busy, fcnt);
    end
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rdy === 1'b1) strobes++;
      if (k == 2) rst_n = 1'b1;
    end
    checks++;
    if (strobes != 0 || fcnt !== 8'd0 || crdy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after strobes=%0d frame_cnt=%0d cmd_ready=%b required 0 0 1", strobes, fcnt, crdy);
    end
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check_frame(F_BASIC, 8'd1, 2, "midrst_clean");
  endtask

  task automatic test_counter_wrap;
    int strobes;
    logic [7:0] cnt_at_255;
    logic [7:0] cnt_at_256;
    sel = 0;
    do_reset();
    strobes = 0;
    cnt_at_255 = 8'hxx;
    cnt_at_256 = 8'hxx;
    set_cmd(4'h5, 16'h0F0F, 16'hF0F0);
    cmd_valid = 1'b1;
    step();
    for (int c = 1; c <= 256 * (int'(FL) + 4); c++) begin
      if (rdy === 1'b1) begin
        strobes++;
        if (strobes == 255) cnt_at_255 = fcnt;
        if (strobes == 256) cnt_at_256 = fcnt;
      end
      if (c != 256 * (int'(FL) + 4)) step();
    end
    cmd_valid = 1'b0;
    checks++;
    if (strobes != 256) begin
      errors++;
      $display("FAIL wrap_strobes got=%0d required=256", strobes);
    end
    checks++;
    if (cnt_at_255 !== 8'd255) begin
      errors++;
      $display("FAIL wrap_cnt255 got=%0d required=255", cnt_at_255);
    end
    checks++;
    if (cnt_at_256 !== 8'd0) begin
      errors++;
      $display("FAIL wrap_cnt0 got=%0d required=0", cnt_at_256);
    end
  endtask

  task automatic test_gap_zero;
    sel = 1;
    do_reset();
    set_cmd(4'h3, 16'h00FF, 16'h0001);
    cmd_valid = 1'b1;
    step();
    check_frame(F_BASIC, 8'd1, 0, "gap0_first");
    step();
    check_frame(F_BASIC, 8'd2, 0, "gap0_second");
    cmd_valid = 1'b0;
    sel = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    test_gap_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
